// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the ASCII drive-command link (robot translator and base receiver).
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        STOP     = 3'd0,
        FORWARD  = 3'd1,
        BACKWARD = 3'd2,
        LEFT     = 3'd3,
        RIGHT    = 3'd4
    } drive_cmd_t;

    typedef struct packed {
        logic       hit;
        drive_cmd_t cmd;
    } cmd_decode_t;

    localparam logic [7:0] ASCII_S = 8'h53;
    localparam logic [7:0] ASCII_F = 8'h46;
    localparam logic [7:0] ASCII_B = 8'h42;
    localparam logic [7:0] ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_R = 8'h52;
    localparam logic [7:0] ASCII_1 = 8'h31;
    localparam logic [7:0] ASCII_5 = 8'h35;

    localparam logic [2:0] DIFF_MIN = 3'd1;
    localparam logic [2:0] DIFF_MAX = 3'd5;

    // Upper-case command letters only; anything else reports hit = 0.
    function automatic cmd_decode_t decode_cmd(input logic [7:0] c);
        cmd_decode_t d;
        d.hit = 1'b1;
        d.cmd = STOP;
        case (c)
            ASCII_S: d.cmd = STOP;
            ASCII_F: d.cmd = FORWARD;
            ASCII_B: d.cmd = BACKWARD;
            ASCII_L: d.cmd = LEFT;
            ASCII_R: d.cmd = RIGHT;
            default: d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM and framing check.
module uart_rx_core #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] rx_byte,
    output logic       rx_commit,     // cycle T: stop bit good, rx_byte complete
    output logic       byte_valid,    // cycle T+1
    output logic       framing_error  // cycle T+1
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        StWaitIdle, StIdle, StStart, StData, StStop, StDone
    } rx_state_t;

    rx_state_t        state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             fe_q, fe_d;
    logic             rx_s;

    assign rx_s          = sync_q[1];
    assign rx_byte       = shift_q;
    assign byte_valid    = (state_q == StDone);
    assign framing_error = fe_q;

    // State, counters and the idle-high synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            state_q   <= StWaitIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            fe_q      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], uart_in};
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            fe_q      <= fe_d;
        end
    end

    // Next-state: all sampling happens at mid-bit, counted from the start-bit edge.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        fe_d      = 1'b0;
        rx_commit = 1'b0;
        case (state_q)
            StWaitIdle: begin
                // Needs a full bit period of continuous high before listening.
                if (!rx_s) begin
                    clk_cnt_d = '0;
                end else if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            StIdle: begin
                if (!rx_s) begin
                    clk_cnt_d = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == CNT_MID) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            StData: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            StStop: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        rx_commit = 1'b1;
                        state_d   = StDone;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = StWaitIdle;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StWaitIdle;
        endcase
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Base-side command receiver: decodes framed bytes into drive commands and difficulty.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    input  logic       cmd_ready,
    output logic [2:0] drive_command,
    output logic       cmd_valid,
    output logic [2:0] difficulty,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic       unknown_char
);
    logic [7:0]  rx_byte;
    logic        rx_commit;
    cmd_decode_t dec;
    logic        is_diff;

    drive_cmd_t  drive_q, drive_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [2:0]  diff_q, diff_d;
    logic [7:0]  byte_q, byte_d;
    logic        overrun_q, overrun_d;
    logic        unknown_q, unknown_d;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .uart_in       (uart_in),
        .rx_byte       (rx_byte),
        .rx_commit     (rx_commit),
        .byte_valid    (byte_valid),
        .framing_error (framing_error)
    );

    assign dec           = decode_cmd(rx_byte);
    assign is_diff       = (rx_byte >= ASCII_1) && (rx_byte <= ASCII_5);
    assign drive_command = drive_q;
    assign cmd_valid     = cmd_valid_q;
    assign difficulty    = diff_q;
    assign byte_data     = byte_q;
    assign overrun       = overrun_q;
    assign unknown_char  = unknown_q;

    // Output registers; loaded on rx_commit so they become visible with byte_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drive_q     <= STOP;
            cmd_valid_q <= 1'b0;
            diff_q      <= DIFF_MIN;
            byte_q      <= 8'h00;
            overrun_q   <= 1'b0;
            unknown_q   <= 1'b0;
        end else begin
            drive_q     <= drive_d;
            cmd_valid_q <= cmd_valid_d;
            diff_q      <= diff_d;
            byte_q      <= byte_d;
            overrun_q   <= overrun_d;
            unknown_q   <= unknown_d;
        end
    end

    // Decode table and handshake; a new command wins over a same-cycle accept.
    always_comb begin
        drive_d     = drive_q;
        cmd_valid_d = cmd_valid_q;
        diff_d      = diff_q;
        byte_d      = byte_q;
        overrun_d   = 1'b0;
        unknown_d   = 1'b0;
        if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
        if (rx_commit) begin
            byte_d = rx_byte;
            if (dec.hit) begin
                drive_d     = dec.cmd;
                cmd_valid_d = 1'b1;
                overrun_d   = cmd_valid_q && !cmd_ready;
            end else if (is_diff) begin
                // '1'..'5' carry the level in their low three bits.
                diff_d = rx_byte[2:0];
            end else begin
                unknown_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: scoreboard of expected receive events.
module tb_uart_cmd_rx;

    localparam int CPB = 50_000_000 / 115200;

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       uart_in;
    logic       cmd_ready;
    logic [2:0] drive_command;
    logic       cmd_valid;
    logic [2:0] difficulty;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       framing_error;
    logic       overrun;
    logic       unknown_char;

    typedef struct {
        logic       fe;
        logic [7:0] data;
        logic [2:0] cmd;
        logic       valid;
        logic [2:0] diff;
        logic       ovr;
        logic       unk;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [2:0] m_cmd       = 3'd0;
    logic       m_valid     = 1'b0;
    logic [2:0] m_diff      = 3'd1;

    uart_cmd_rx u_dut (
        .clk           (clk_50),
        .reset         (reset),
        .uart_in       (uart_in),
        .cmd_ready     (cmd_ready),
        .drive_command (drive_command),
        .cmd_valid     (cmd_valid),
        .difficulty    (difficulty),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .framing_error (framing_error),
        .overrun       (overrun),
        .unknown_char  (unknown_char)
    );

    always #10 clk_50 = ~clk_50;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_in = b;
        repeat (CPB) @(negedge clk_50);
    endtask

    task automatic idle(input int bits);
        uart_in = 1'b1;
        repeat (bits * CPB) @(negedge clk_50);
    endtask

    // Update the reference model, queue the expected event, then drive the frame.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        exp_t e;
        logic hit;
        logic [2:0] c;
        hit = 1'b1;
        c   = 3'd0;
        case (b)
            8'h53:   c = 3'd0;
            8'h46:   c = 3'd1;
            8'h42:   c = 3'd2;
            8'h4C:   c = 3'd3;
            8'h52:   c = 3'd4;
            default: hit = 1'b0;
        endcase
        e.fe   = !stop_ok;
        e.data = b;
        e.ovr  = 1'b0;
        e.unk  = 1'b0;
        if (stop_ok) begin
            if (hit) begin
                e.ovr   = m_valid;
                m_cmd   = c;
                m_valid = 1'b1;
            end else if (b >= 8'h31 && b <= 8'h35) begin
                m_diff = 3'(b - 8'h30);
            end else begin
                e.unk = 1'b1;
            end
        end
        e.cmd   = m_cmd;
        e.valid = m_valid;
        e.diff  = m_diff;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
    endtask

    task automatic accept(input string tag);
        check({tag, "_valid_pre"}, cmd_valid, 1);
        cmd_ready = 1'b1;
        @(negedge clk_50);
        cmd_ready = 1'b0;
        m_valid   = 1'b0;
        check({tag, "_valid_post"}, cmd_valid, 0);
    endtask

    task automatic drained(input string tag);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // Every receive event pops one expectation; any unexpected pulse is a miscompare.
    always @(negedge clk_50) begin
        if (!reset && (byte_valid || framing_error || overrun || unknown_char)) begin
            if (exp_q.size() == 0 || !(byte_valid || framing_error)) begin
                check("stray_event", {byte_valid, framing_error, overrun, unknown_char}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.fe) begin
                    check("fe_flag", framing_error, 1);
                    check("fe_byte_valid", byte_valid, 0);
                    check("fe_cmd_valid", cmd_valid, mon_e.valid);
                end else begin
                    check("rx_framing", framing_error, 0);
                    check("rx_byte_data", byte_data, mon_e.data);
                    check("rx_drive_command", drive_command, mon_e.cmd);
                    check("rx_cmd_valid", cmd_valid, mon_e.valid);
                    check("rx_difficulty", difficulty, mon_e.diff);
                    check("rx_overrun", overrun, mon_e.ovr);
                    check("rx_unknown", unknown_char, mon_e.unk);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_drive"}, drive_command, 0);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_difficulty"}, difficulty, 1);
        check({tag, "_byte_data"}, byte_data, 8'h00);
        check({tag, "_flags"}, {byte_valid, framing_error, overrun, unknown_char}, 0);
    endtask

    initial begin
        reset     = 1'b1;
        uart_in   = 1'b1;
        cmd_ready = 1'b0;
        repeat (5) @(negedge clk_50);
        check_reset_values("reset");
        reset = 1'b0;
        idle(2);

        // Single command held until accepted.
        send_byte(8'h46, 1'b1);
        idle(1);
        drained("F");
        check("F_held_valid", cmd_valid, 1);
        check("F_held_cmd", drive_command, 1);
        accept("F");

        // Difficulty then command, back-to-back.
        send_byte(8'h33, 1'b1);
        send_byte(8'h4C, 1'b1);
        idle(1);
        drained("3L");
        check("3L_difficulty", difficulty, 3);
        accept("L");

        // Bad stop bit, then a break that must not start a frame before idle.
        send_byte(8'h52, 1'b0);
        send_bit(1'b0);
        idle(2);
        drained("R_fe");
        check("R_no_valid", cmd_valid, 0);
        send_byte(8'h53, 1'b1);
        idle(1);
        drained("S");
        accept("S");

        // Short low glitch on an idle line.
        uart_in = 1'b0;
        repeat (100) @(negedge clk_50);
        idle(2);
        drained("glitch");
        check("glitch_byte_kept", byte_data, 8'h53);
        send_byte(8'h42, 1'b1);
        idle(1);
        drained("B");
        accept("B");

        // Overrun, unknown char and difficulty boundaries with cmd_ready low.
        send_byte(8'h46, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h35, 1'b1);
        send_byte(8'h36, 1'b1);
        idle(1);
        drained("ovr");
        check("ovr_cmd", drive_command, 2);
        check("ovr_valid", cmd_valid, 1);
        check("ovr_difficulty", difficulty, 5);
        accept("ovr");

        // Reset in the middle of the data bits of 'F'.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        uart_in = 1'b0;
        reset   = 1'b1;
        m_cmd   = 3'd0;
        m_valid = 1'b0;
        m_diff  = 3'd1;
        @(negedge clk_50);
        check_reset_values("midreset");
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        send_bit(1'b0);
        send_bit(1'b0);
        drained("midreset_low");
        idle(2);
        send_byte(8'h53, 1'b1);
        idle(1);
        drained("midreset_S");
        check("midreset_S_valid", cmd_valid, 1);
        check("midreset_S_cmd", drive_command, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
